// File: rtl/pipe_addsub.sv
`default_nettype none
// ============================================================================
// Module   : pipe_addsub
// Purpose  : Pipelined WIDTH-bit adder/subtractor. Each pipeline stage
//            resolves one CHUNK-bit ripple slice using the carry registered
//            by the previous stage. Valid/ready handshake on both sides,
//            with one global stall enable for every stage register.
// Ports    : clk       - clock, rising edge
//            rst_n     - asynchronous active-low reset
//            in_valid  - operand beat present
//            in_ready  - beat accepted this cycle if in_valid is high
//            a, b      - WIDTH-bit operands
//            cin       - carry-in (add) / borrow-in (subtract)
//            sub       - 0 = add, 1 = subtract
//            out_valid - result beat present
//            out_ready - downstream accepts result
//            sum       - WIDTH-bit result
//            cout      - carry-out (add) / borrow-out (subtract)
//            ovf       - two's-complement signed overflow
// Revision : 1.0 - initial release
// ============================================================================
module pipe_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int LAST   = STAGES - 1;

  // One past the MSB of the chunk resolved by stage k; the last chunk
  // absorbs the ragged remainder.
  function automatic int f_top(input int k);
    return (k == LAST) ? WIDTH : (k + 1) * CHUNK;
  endfunction

  logic                en;
  logic [STAGES-1:0]   valid_q, valid_d;

  // Per-stage registers. Operands travel with the beat; b is stored already
  // conditioned for subtraction (a + ~b + !cin).
  logic [WIDTH-1:0]    a_q   [STAGES];
  logic [WIDTH-1:0]    a_d   [STAGES];
  logic [WIDTH-1:0]    b_q   [STAGES];
  logic [WIDTH-1:0]    b_d   [STAGES];
  logic [WIDTH-1:0]    s_q   [STAGES];
  logic [WIDTH-1:0]    s_d   [STAGES];
  logic                c_q   [STAGES];
  logic                c_d   [STAGES];
  logic                sub_q [STAGES];
  logic                sub_d [STAGES];
  logic                ovf_q, ovf_d;

  // Inputs seen by each stage and its slice arithmetic.
  logic [WIDTH-1:0]    a_in   [STAGES];
  logic [WIDTH-1:0]    b_in   [STAGES];
  logic [WIDTH-1:0]    s_in   [STAGES];
  logic                c_in   [STAGES];
  logic                sub_in [STAGES];
  logic [WIDTH:0]      m      [STAGES];
  logic [WIDTH:0]      cm     [STAGES];
  logic [WIDTH:0]      t      [STAGES];
  logic                co     [STAGES];

  always_comb begin
    en        = !valid_q[LAST] || out_ready;

    a_in[0]    = a;
    b_in[0]    = b ^ {WIDTH{sub}};
    c_in[0]    = cin ^ sub;
    sub_in[0]  = sub;
    s_in[0]    = '0;
    valid_d[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_in[k]    = a_q[k-1];
      b_in[k]    = b_q[k-1];
      c_in[k]    = c_q[k-1];
      sub_in[k]  = sub_q[k-1];
      s_in[k]    = s_q[k-1];
      valid_d[k] = valid_q[k-1];
    end

    for (int k = 0; k < STAGES; k++) begin
      // Masked full-width add: only the chunk bits are non-zero, so this
      // reduces to a CHUNK-bit ripple whose carry lands at bit f_top(k).
      m[k]     = ({(WIDTH+1){1'b1}} << (k * CHUNK)) & ~({(WIDTH+1){1'b1}} << f_top(k));
      cm[k]    = {{WIDTH{1'b0}}, 1'b1} << f_top(k);
      t[k]     = ({1'b0, a_in[k]} & m[k]) + ({1'b0, b_in[k]} & m[k])
               + ({{WIDTH{1'b0}}, c_in[k]} << (k * CHUNK));
      co[k]    = |(t[k] & cm[k]);
      s_d[k]   = (s_in[k] & ~m[k][WIDTH-1:0]) | (t[k][WIDTH-1:0] & m[k][WIDTH-1:0]);
      a_d[k]   = a_in[k];
      b_d[k]   = b_in[k];
      sub_d[k] = sub_in[k];
      c_d[k]   = co[k];
    end

    // Final stage: carry becomes borrow when subtracting. Carry into the MSB
    // is recovered as a ^ b ^ sum at that bit.
    c_d[LAST] = co[LAST] ^ sub_in[LAST];
    ovf_d     = a_in[LAST][WIDTH-1] ^ b_in[LAST][WIDTH-1] ^ t[LAST][WIDTH-1] ^ co[LAST];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
        c_q[k]   <= 1'b0;
        sub_q[k] <= 1'b0;
      end
    end else if (en) begin
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        s_q[k]   <= s_d[k];
        c_q[k]   <= c_d[k];
        sub_q[k] <= sub_d[k];
      end
    end
  end

  assign in_ready  = en;
  assign out_valid = valid_q[LAST];
  assign sum       = s_q[LAST];
  assign cout      = c_q[LAST];
  assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_addsub.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_addsub
// Purpose  : Self-checking bench for pipe_addsub (16/4 and ragged 10/4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_addsub;

  localparam int NRAND = 300;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, sum;
  logic        cin, sub, cout, ovf;

  logic        r_in_valid, r_in_ready, r_out_valid, r_out_ready;
  logic [9:0]  r_a, r_b, r_sum;
  logic        r_cin, r_sub, r_cout, r_ovf;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_addsub #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  pipe_addsub #(.WIDTH(10), .CHUNK(4)) dut_r (
    .clk(clk), .rst_n(rst_n), .in_valid(r_in_valid), .in_ready(r_in_ready),
    .a(r_a), .b(r_b), .cin(r_cin), .sub(r_sub), .out_valid(r_out_valid),
    .out_ready(r_out_ready), .sum(r_sum), .cout(r_cout), .ovf(r_ovf)
  );

  // Reference: plain integer arithmetic on unsigned and signed views.
  // Returns {ovf, cout, sum(zero-extended to 16)}.
  function automatic logic [17:0] ref_model(input int w, input int ia, input int ib,
                                            input int icin, input int isub);
    int full, half, sa, sb, ur, r;
    logic co, ov;
    full = 1 << w;
    half = 1 << (w - 1);
    sa = (ia >= half) ? ia - full : ia;
    sb = (ib >= half) ? ib - full : ib;
    if (isub != 0) begin
      ur = ia - ib - icin;
      r  = sa - sb - icin;
      co = (ur < 0);
    end else begin
      ur = ia + ib + icin;
      r  = sa + sb + icin;
      co = (ur >= full);
    end
    ov = (r < -half) || (r >= half);
    return {ov, co, 16'(ur & (full - 1))};
  endfunction

  task automatic run_beat(input logic [15:0] ia, input logic [15:0] ib, input logic icin,
                          input logic isub, output logic [15:0] osum, output logic ocout,
                          output logic oovf, output int lat);
    @(negedge clk);
    in_valid = 1'b1; a = ia; b = ib; cin = icin; sub = isub; out_ready = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    osum = sum; ocout = cout; oovf = ovf;
  endtask

  task automatic run_beat_r(input logic [9:0] ia, input logic [9:0] ib, input logic icin,
                            input logic isub, output logic [9:0] osum, output logic ocout,
                            output logic oovf, output int lat);
    @(negedge clk);
    r_in_valid = 1'b1; r_a = ia; r_b = ib; r_cin = icin; r_sub = isub; r_out_ready = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    r_in_valid = 1'b0;
    while (r_out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    osum = r_sum; ocout = r_cout; oovf = r_ovf;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    r_in_valid = 1'b0; r_out_ready = 1'b1; r_a = '0; r_b = '0; r_cin = 1'b0; r_sub = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({out_valid, sum, cout, ovf} !== 19'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0", {out_valid, sum, cout, ovf});
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, sum, cout, ovf, in_ready} !== 20'd1) begin
      failures++;
      $display("FAIL reset_release got=%h want=1", {out_valid, sum, cout, ovf, in_ready});
    end
    out_ready = 1'b1;
  endtask

  task automatic test_add();
    logic [15:0] s;
    logic co, ov;
    int lat;
    run_beat(16'hFFFF, 16'h0001, 1'b0, 1'b0, s, co, ov, lat);
    checks++;
    if ({s, co, ov} !== {16'h0000, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL add_ffff got=%h/%b/%b want=0000/1/0", s, co, ov);
    end
    checks++;
    if (lat != 4) begin
      failures++;
      $display("FAIL add_latency got=%0d want=4", lat);
    end
    run_beat(16'h7FFF, 16'h0001, 1'b0, 1'b0, s, co, ov, lat);
    checks++;
    if ({s, co, ov} !== {16'h8000, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL add_7fff got=%h/%b/%b want=8000/0/1", s, co, ov);
    end
  endtask

  task automatic test_sub();
    logic [15:0] s;
    logic co, ov;
    int lat;
    run_beat(16'h0005, 16'h0007, 1'b0, 1'b1, s, co, ov, lat);
    checks++;
    if ({s, co, ov} !== {16'hFFFE, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL sub_5_7 got=%h/%b/%b want=fffe/1/0", s, co, ov);
    end
    run_beat(16'h8000, 16'h0001, 1'b0, 1'b1, s, co, ov, lat);
    checks++;
    if ({s, co, ov} !== {16'h7FFF, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL sub_8000_1 got=%h/%b/%b want=7fff/0/1", s, co, ov);
    end
    run_beat(16'h0010, 16'h0010, 1'b1, 1'b1, s, co, ov, lat);
    checks++;
    if ({s, co} !== {16'hFFFF, 1'b1}) begin
      failures++;
      $display("FAIL sub_borrow_in got=%h/%b want=ffff/1", s, co);
    end
    checks++;
    if (lat != 4) begin
      failures++;
      $display("FAIL sub_latency got=%0d want=4", lat);
    end
  endtask

  task automatic test_back_to_back();
    int sent, got, cyc, stall_left, ir_low, extra;
    logic seen, hold;
    logic [17:0] prev;
    sent = 0; got = 0; cyc = 0; stall_left = 0; ir_low = 0; extra = 0;
    seen = 1'b0; hold = 1'b0; prev = '0;
    out_ready = 1'b1; in_valid = 1'b0;
    while (got < 6 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (hold) begin
        checks++;
        if ({out_valid, ovf, cout, sum} !== {1'b1, prev}) begin
          failures++;
          $display("FAIL bp_hold got=%h want=%h", {out_valid, ovf, cout, sum}, {1'b1, prev});
        end
      end
      if (!seen && out_valid === 1'b1) begin
        seen = 1'b1;
        stall_left = 3;
      end
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
      if (sent < 6) begin
        in_valid = 1'b1; a = 16'(sent + 1); b = 16'(256 * (sent + 1)); cin = 1'b0; sub = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_ready !== 1'b1) ir_low++;
      if (out_valid === 1'b1 && out_ready) begin
        got++;
        checks++;
        if ({ovf, cout, sum} !== {2'b00, 16'(257 * got)}) begin
          failures++;
          $display("FAIL bp_result%0d got=%h want=%h", got, {ovf, cout, sum}, {2'b00, 16'(257 * got)});
        end
      end
      hold = (out_valid === 1'b1) && !out_ready;
      prev = {ovf, cout, sum};
      if (in_valid && in_ready === 1'b1) sent++;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (out_valid !== 1'b0) extra++;
    end
    checks++;
    if (got != 6 || sent != 6) begin
      failures++;
      $display("FAIL bp_count got=%0d/%0d want=6/6", got, sent);
    end
    checks++;
    if (ir_low != 3) begin
      failures++;
      $display("FAIL bp_in_ready_low got=%0d want=3", ir_low);
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL bp_duplicate got=%0d want=0", extra);
    end
  endtask

  task automatic test_ragged();
    logic [9:0]  s;
    logic        co, ov;
    logic [9:0]  ra, rb;
    logic        rc, rs;
    logic [17:0] e;
    int lat, bad;
    run_beat_r(10'h3FF, 10'h001, 1'b0, 1'b0, s, co, ov, lat);
    checks++;
    if ({s, co, ov} !== {10'h000, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL ragged_3ff got=%h/%b/%b want=000/1/0", s, co, ov);
    end
    checks++;
    if (lat != 3) begin
      failures++;
      $display("FAIL ragged_latency got=%0d want=3", lat);
    end
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      ra = 10'($urandom); rb = 10'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      run_beat_r(ra, rb, rc, rs, s, co, ov, lat);
      e = ref_model(10, int'(ra), int'(rb), int'(rc), int'(rs));
      checks++;
      if ({ov, co, s} !== {e[17:16], e[9:0]} || lat != 3) begin
        failures++;
        bad++;
        $display("FAIL ragged_rand a=%h b=%h cin=%b sub=%b got=%h lat=%0d want=%h lat=3",
                 ra, rb, rc, rs, {ov, co, s}, lat, {e[17:16], e[9:0]});
      end
    end
  endtask

  task automatic test_random_stream();
    logic [17:0] expq[$];
    logic [17:0] exp_v, prev;
    logic        hold, took;
    int          acc, rcv, cyc;
    hold = 1'b0; took = 1'b0; prev = '0; acc = 0; rcv = 0; cyc = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    while (rcv < NRAND && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      if (took) in_valid = 1'b0;
      if (!in_valid && acc < NRAND && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        if ($urandom_range(0, 7) == 0) a = 16'h8000;
        if ($urandom_range(0, 7) == 0) b = 16'hFFFF;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (hold) begin
        checks++;
        if ({out_valid, ovf, cout, sum} !== {1'b1, prev}) begin
          failures++;
          $display("FAIL rnd_hold got=%h want=%h", {out_valid, ovf, cout, sum}, {1'b1, prev});
        end
      end
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        failures++;
        $display("FAIL rnd_in_ready got=%b want=%b", in_ready, !out_valid || out_ready);
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (expq.size() == 0) begin
          failures++;
          $display("FAIL rnd_unexpected got=%h want=none", {ovf, cout, sum});
        end else begin
          exp_v = expq.pop_front();
          if ({ovf, cout, sum} !== exp_v) begin
            failures++;
            $display("FAIL rnd_result%0d got=%h want=%h", rcv, {ovf, cout, sum}, exp_v);
          end
        end
        rcv++;
      end
      hold = (out_valid === 1'b1) && !out_ready;
      prev = {ovf, cout, sum};
      took = in_valid && (in_ready === 1'b1);
      if (took) begin
        expq.push_back(ref_model(16, int'(a), int'(b), int'(cin), int'(sub)));
        acc++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (rcv != NRAND || expq.size() != 0) begin
      failures++;
      $display("FAIL rnd_count got=%0d left=%0d want=%0d left=0", rcv, expq.size(), NRAND);
    end
  endtask

  task automatic test_reset_midstream();
    logic [15:0] s;
    logic co, ov;
    int lat, stale;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 16'(i + 1); b = 16'h0010; cin = 1'b0; sub = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if ({out_valid, sum} !== {1'b1, 16'h0011}) begin
      failures++;
      $display("FAIL mid_pre got=%h want=10011", {out_valid, sum});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, sum, cout, ovf} !== 19'd0) begin
      failures++;
      $display("FAIL mid_async_clear got=%h want=0", {out_valid, sum, cout, ovf});
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_in_ready got=%b want=1", in_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0) begin
      failures++;
      $display("FAIL mid_stale got=%0d want=0", stale);
    end
    run_beat(16'h0002, 16'h0003, 1'b0, 1'b0, s, co, ov, lat);
    checks++;
    if ({s, co, ov} !== {16'h0005, 1'b0, 1'b0} || lat != 4) begin
      failures++;
      $display("FAIL mid_new_beat got=%h/%b/%b lat=%0d want=0005/0/0 lat=4", s, co, ov, lat);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_ragged();
    test_random_stream();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
